// File: rtl/patch_ram_pkg.sv
// Shared definitions for the patch bank RAM and the patch generator.
//   clr_state_t  : clear sequencer state encoding
//   PATCH_*      : default lane count, lane width and depth
//   cnt_width()  : address/counter width for a given depth (minimum 1)
//   PATCH_LANE   : lane slice of a packed multi-lane vector
`ifndef PATCH_RAM_PKG_SV
`define PATCH_RAM_PKG_SV

`define PATCH_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]

package patch_ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  localparam int PATCH_NUM_CH = 12;
  localparam int PATCH_DATA_W = 8;
  localparam int PATCH_DEPTH  = 2048;

  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`endif

// File: rtl/patch_bank_lane.sv
// One lane of the patch store: simple dual-port DATA_W x DEPTH memory,
// synchronous write and synchronous read, written to infer block RAM.
//   clk      : clock
//   wr_en    : write strobe, wr_addr/wr_data stored at the rising edge
//   rd_en    : read strobe, rd_data updates at the rising edge, else holds
// Contents and rd_data are not reset.
module patch_bank_lane #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-first on address collision; the top level provides write-first bypass.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/patch_bank_ram.sv
// Multi-lane patch store: NUM_CH lanes sharing one write and one read address,
// with per-lane write mask, write-first bypass, RD_LAT 1/2 read pipeline,
// hardware zero-fill sequencer and sticky out-of-range error flag.
//   clk, rst           : clock, async active-high reset
//   clr_start/clr_busy : start zero-fill of all lanes / fill in progress
//   wr_en/wr_mask/wr_addr/wr_data : masked lane write
//   rd_en/rd_addr      : read request
//   rd_data/rd_valid   : read result, RD_LAT cycles after rd_en
//   addr_err           : sticky, access at addr >= DEPTH attempted
//
// state    | meaning
// ST_IDLE  | normal read/write traffic accepted
// ST_CLEAR | zero-filling address clr_cnt in every lane, traffic ignored
module patch_bank_ram
  import patch_ram_pkg::*;
#(
  parameter int NUM_CH = PATCH_NUM_CH,
  parameter int DATA_W = PATCH_DATA_W,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = PATCH_DEPTH,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_start,
  output logic                     clr_busy,
  input  logic                     wr_en,
  input  logic [NUM_CH-1:0]        wr_mask,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     addr_err
);

  localparam int CNT_W = cnt_width(DEPTH);

  clr_state_t        state;
  logic [CNT_W-1:0]  clr_cnt;

  logic idle;
  logic wr_in, rd_in;
  logic wr_ok, rd_ok, rd_mem, byp_hit;
  logic [CNT_W-1:0]  lane_waddr;
  logic [NUM_CH*DATA_W-1:0] lane_q;

  assign idle    = (state == ST_IDLE);
  assign wr_in   = ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));
  assign rd_in   = ({1'b0, rd_addr} < (ADDR_W+1)'(DEPTH));
  assign wr_ok   = idle && wr_en && wr_in;
  assign rd_ok   = idle && rd_en;
  assign rd_mem  = rd_ok && rd_in;
  assign byp_hit = wr_ok && rd_mem && (wr_addr == rd_addr);

  assign lane_waddr = idle ? wr_addr[CNT_W-1:0] : clr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      clr_cnt  <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state    <= ST_CLEAR;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == CNT_W'(DEPTH-1)) begin
            state    <= ST_IDLE;
            clr_busy <= 1'b0;
          end else begin
            clr_cnt  <= clr_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    patch_bank_lane #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (CNT_W)
    ) u_lane (
      .clk     (clk),
      .wr_en   (!idle || (wr_ok && wr_mask[i])),
      .wr_addr (lane_waddr),
      .wr_data (idle ? `PATCH_LANE(wr_data, i, DATA_W) : '0),
      .rd_en   (rd_mem),
      .rd_addr (rd_addr[CNT_W-1:0]),
      .rd_data (`PATCH_LANE(lane_q, i, DATA_W))
    );
  end

  // First read stage: side information captured alongside the lane read.
  // All of it only updates on an accepted read so rd_data holds otherwise.
  // zero1 resets high so rd_data reads as zero out of reset even though
  // the lane output registers are not reset.
  logic                     v1;
  logic                     zero1;
  logic [NUM_CH-1:0]        byp1;
  logic [NUM_CH*DATA_W-1:0] byp_data1;
  logic [NUM_CH*DATA_W-1:0] rd_data1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      zero1     <= 1'b1;
      byp1      <= '0;
      byp_data1 <= '0;
    end else begin
      v1 <= rd_ok;
      if (rd_ok) begin
        zero1     <= !rd_in;
        byp1      <= byp_hit ? wr_mask : '0;
        byp_data1 <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data1 = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (zero1)
        `PATCH_LANE(rd_data1, i, DATA_W) = '0;
      else if (byp1[i])
        `PATCH_LANE(rd_data1, i, DATA_W) = `PATCH_LANE(byp_data1, i, DATA_W);
      else
        `PATCH_LANE(rd_data1, i, DATA_W) = `PATCH_LANE(lane_q, i, DATA_W);
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [NUM_CH*DATA_W-1:0] rd_data_q;
    logic                     rd_valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= v1;
        if (v1) rd_data_q <= rd_data1;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end else begin : g_lat1
    assign rd_data  = rd_data1;
    assign rd_valid = v1;
  end

  // An accepted clr_start wins over an out-of-range access in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else if (idle && clr_start) begin
      addr_err <= 1'b0;
    end else if (idle && ((wr_en && !wr_in) || (rd_en && !rd_in))) begin
      addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_patch_bank_ram.sv
module tb_patch_bank_ram;

  localparam int BW = 96;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance a: DEPTH 2048, ADDR_W 11, RD_LAT 1
  logic          a_clr_start, a_clr_busy, a_wr_en, a_rd_en, a_rd_valid, a_addr_err;
  logic [11:0]   a_wr_mask;
  logic [10:0]   a_wr_addr, a_rd_addr;
  logic [BW-1:0] a_wr_data, a_rd_data;

  // instance b: DEPTH 1000, ADDR_W 10, RD_LAT 2
  logic          b_clr_start, b_clr_busy, b_wr_en, b_rd_en, b_rd_valid, b_addr_err;
  logic [11:0]   b_wr_mask;
  logic [9:0]    b_wr_addr, b_rd_addr;
  logic [BW-1:0] b_wr_data, b_rd_data;

  patch_bank_ram #(.NUM_CH(12), .DATA_W(8), .ADDR_W(11), .DEPTH(2048), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .clr_start(a_clr_start), .clr_busy(a_clr_busy),
    .wr_en(a_wr_en), .wr_mask(a_wr_mask), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .addr_err(a_addr_err)
  );

  patch_bank_ram #(.NUM_CH(12), .DATA_W(8), .ADDR_W(10), .DEPTH(1000), .RD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .clr_start(b_clr_start), .clr_busy(b_clr_busy),
    .wr_en(b_wr_en), .wr_mask(b_wr_mask), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .addr_err(b_addr_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] fill(input logic [7:0] b);
    return {12{b}};
  endfunction

  function automatic logic [BW-1:0] lanes_inc();
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < 12; i++) v[i*8 +: 8] = 8'(i + 1);
    return v;
  endfunction

  task automatic a_wr(input logic [10:0] addr, input logic [11:0] mask, input logic [BW-1:0] data);
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_mask = mask; a_wr_data = data;
    tick();
    a_wr_en = 1'b0;
  endtask

  task automatic a_rd_chk(input string tag, input logic [10:0] addr, input logic [BW-1:0] exp);
    a_rd_en = 1'b1; a_rd_addr = addr;
    tick();
    a_rd_en = 1'b0;
    chk({tag, "_vld"}, {95'b0, a_rd_valid}, 1);
    chk(tag, a_rd_data, exp);
  endtask

  task automatic b_wr(input logic [9:0] addr, input logic [11:0] mask, input logic [BW-1:0] data);
    b_wr_en = 1'b1; b_wr_addr = addr; b_wr_mask = mask; b_wr_data = data;
    tick();
    b_wr_en = 1'b0;
  endtask

  task automatic b_rd_chk(input string tag, input logic [9:0] addr, input logic [BW-1:0] exp);
    b_rd_en = 1'b1; b_rd_addr = addr;
    tick();
    b_rd_en = 1'b0;
    chk({tag, "_vld_early"}, {95'b0, b_rd_valid}, 0);
    tick();
    chk({tag, "_vld"}, {95'b0, b_rd_valid}, 1);
    chk(tag, b_rd_data, exp);
  endtask

  int busy_cycles;
  bit seen_valid;

  initial begin
    a_clr_start = 0; a_wr_en = 0; a_rd_en = 0; a_wr_mask = '0; a_wr_addr = '0;
    a_rd_addr = '0; a_wr_data = '0;
    b_clr_start = 0; b_wr_en = 0; b_rd_en = 0; b_wr_mask = '0; b_wr_addr = '0;
    b_rd_addr = '0; b_wr_data = '0;

    repeat (2) tick();
    chk("a_rst_busy", {95'b0, a_clr_busy}, 0);
    chk("a_rst_vld",  {95'b0, a_rd_valid}, 0);
    chk("a_rst_data", a_rd_data, 0);
    chk("a_rst_err",  {95'b0, a_addr_err}, 0);
    chk("b_rst_vld",  {95'b0, b_rd_valid}, 0);
    chk("b_rst_data", b_rd_data, 0);
    rst = 1'b0;
    tick();

    // basic write/read, lane i = i+1
    a_wr(11'd5, 12'hFFF, lanes_inc());
    a_rd_chk("a_basic", 11'd5, lanes_inc());
    tick();
    chk("a_vld_pulse", {95'b0, a_rd_valid}, 0);
    chk("a_hold", a_rd_data, lanes_inc());

    // per-lane mask
    a_wr(11'd7, 12'hFFF, fill(8'hAA));
    a_wr(11'd7, 12'h001, {{11{8'h00}}, 8'h55});
    a_rd_chk("a_mask", 11'd7, {{11{8'hAA}}, 8'h55});

    // write-first bypass on same-cycle collision
    a_wr(11'd3, 12'hFFF, fill(8'h11));
    a_wr_en = 1; a_wr_addr = 11'd3; a_wr_mask = 12'hF00; a_wr_data = fill(8'h77);
    a_rd_en = 1; a_rd_addr = 11'd3;
    tick();
    a_wr_en = 0; a_rd_en = 0;
    chk("a_byp_vld", {95'b0, a_rd_valid}, 1);
    chk("a_byp", a_rd_data, {{4{8'h77}}, {8{8'h11}}});
    a_rd_chk("a_byp_stored", 11'd3, {{4{8'h77}}, {8{8'h11}}});

    // top address, then clear
    a_wr(11'd0, 12'hFFF, fill(8'h33));
    a_wr(11'd2047, 12'hFFF, fill(8'h44));
    a_rd_chk("a_top_addr", 11'd2047, fill(8'h44));

    a_clr_start = 1;
    tick();
    a_clr_start = 0;
    chk("a_clr_busy_on", {95'b0, a_clr_busy}, 1);
    busy_cycles = a_clr_busy ? 1 : 0;
    seen_valid = 0;
    a_wr_en = 1; a_wr_addr = 11'd9; a_wr_mask = 12'hFFF; a_wr_data = fill(8'hCC);
    a_rd_en = 1; a_rd_addr = 11'd5;
    for (int k = 0; k < 3000 && a_clr_busy; k++) begin
      a_clr_start = (k == 100);
      tick();
      if (a_clr_busy) busy_cycles++;
      if (a_rd_valid) seen_valid = 1;
    end
    a_clr_start = 0; a_wr_en = 0; a_rd_en = 0;
    chk("a_clr_len", BW'(busy_cycles), BW'(2048));
    chk("a_clr_no_vld", {95'b0, seen_valid}, 0);
    a_rd_chk("a_clr_0", 11'd0, 0);
    a_rd_chk("a_clr_5", 11'd5, 0);
    a_rd_chk("a_clr_top", 11'd2047, 0);
    a_rd_chk("a_clr_wr_ignored", 11'd9, 0);
    chk("a_no_err", {95'b0, a_addr_err}, 0);

    // instance b: latency 2, range checks
    b_wr(10'd20, 12'hFFF, fill(8'h5A));
    b_wr(10'd0, 12'hFFF, fill(8'h66));
    b_rd_chk("b_lat2", 10'd20, fill(8'h5A));
    chk("b_err_clean", {95'b0, b_addr_err}, 0);
    b_wr(10'd1010, 12'hFFF, fill(8'h99));
    chk("b_err_wr", {95'b0, b_addr_err}, 1);
    b_rd_chk("b_oor_wr_rd", 10'd1010, 0);

    b_clr_start = 1;
    tick();
    b_clr_start = 0;
    chk("b_clr_err_cleared", {95'b0, b_addr_err}, 0);
    chk("b_clr_busy_on", {95'b0, b_clr_busy}, 1);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("b_abort_busy", {95'b0, b_clr_busy}, 0);
    chk("b_abort_vld", {95'b0, b_rd_valid}, 0);
    tick();
    rst = 1'b0;
    tick();
    b_rd_chk("b_abort_low", 10'd0, 0);
    b_rd_chk("b_abort_keep", 10'd20, fill(8'h5A));
    b_rd_chk("b_oor_rd", 10'd1005, 0);
    chk("b_err_rd", {95'b0, b_addr_err}, 1);

    // back-to-back reads at 0..3
    for (int k = 0; k < 4; k++) b_wr(10'(k), 12'hFFF, fill(8'(8'hA0 + k)));
    for (int t = 0; t < 7; t++) begin
      b_rd_en = (t < 4);
      b_rd_addr = 10'(t);
      tick();
      chk("b_b2b_vld", {95'b0, b_rd_valid}, {95'b0, (t >= 1 && t <= 4)});
      if (t >= 1 && t <= 4) chk("b_b2b_data", b_rd_data, fill(8'(8'hA0 + t - 1)));
    end
    b_rd_en = 0;
    chk("b_b2b_hold", b_rd_data, fill(8'hA3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
